if_stage_dual: RTL
==================

Name: if_stage_dual

Overview:
- Dual-wide instruction fetch stage. Produces the instr_1/instr_2, pc_out_1/pc_out_2 pair consumed by the decode stage each cycle.
- Reads aligned two-word blocks from a combinational instruction memory into a small fetch queue. The queue decouples fetch from decode stalls.
- Issues up to two in-order instructions per cycle, with per-slot valid bits.
- Handles stall from decode hazard detection and PC redirect from branch/jump resolution.

Parameters:
- QDEPTH, 4, fetch queue depth in entries; power of 2, >= 4.
- RESET_PC, 16'h0000, fetch PC after reset.
- NOP, 16'h0000, instruction driven on invalid slots (ADI R0,R0,0).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-high
- imem_addr  output  16  block address = {fetch_pc[15:1],1'b0}; combinational from fetch_pc
- imem_rdata_1  input  16  mem[imem_addr], same cycle
- imem_rdata_2  input  16  mem[imem_addr+1], same cycle
- stall  input  1  decode cannot accept; hold outputs
- redirect_valid  input  1  flush and restart fetch
- redirect_pc  input  16  new fetch PC
- instr_1  output  16  older issued instruction
- instr_2  output  16  younger issued instruction
- pc_out_1  output  16  PC of instr_1
- pc_out_2  output  16  PC of instr_2
- valid_1  output  1  instr_1 slot valid
- valid_2  output  1  instr_2 slot valid
- q_count  output  $clog2(QDEPTH)+1  queue occupancy

Behaviour:
- Reset (async, immediate):
  - fetch_pc=RESET_PC; queue empty; q_count=0.
  - instr_1=instr_2=NOP; valid_1=valid_2=0.
  - pc_out_1=RESET_PC, pc_out_2=RESET_PC+1.
  - Reset asserted mid-operation discards all queued and issued state.
- Queue entry = {instr[15:0], pc[15:0]}. Circular buffer with head/tail pointers, wrapping modulo QDEPTH.
- Fetch (per edge):
  - Enabled when !redirect_valid && q_count <= QDEPTH-2. q_count is the value before this cycle's pops.
  - fetch_pc even: push rdata_1 (pc=fetch_pc) then rdata_2 (pc=fetch_pc+1); fetch_pc += 2.
  - fetch_pc odd: push only rdata_2 (pc=fetch_pc); fetch_pc += 1.
  - All PC arithmetic is 16-bit, wrapping FFFF->0000.
  - Fetch is independent of stall; the queue fills until the enable condition fails.
- Issue (per edge, output registers):
  - redirect_valid takes priority over everything else. Flush the queue (q_count=0) and set fetch_pc=redirect_pc. Outputs go NOP with valid_1=valid_2=0; pc_out_1=redirect_pc, pc_out_2=redirect_pc+1. No push and no pop that cycle.
  - Else if stall: all outputs hold; no pop.
  - Else if count>=2: pop two. Head goes to slot 1, next entry to slot 2; both valid.
  - Else if count==1: pop one to slot 1 with valid_1=1. valid_2=0, instr_2=NOP, pc_out_2=pc_out_1+1.
  - Else (count==0): valid_1=valid_2=0, instrs NOP, PCs hold.
- Entries pushed on an edge are not poppable on that same edge.
- q_count_next = q_count + pushed - popped. Simultaneous push/pop is legal.
- Overflow is impossible by the fetch condition; underflow is impossible by the count checks.
- Latency:
  - Block address presented in cycle N is pushed at edge N.
  - It appears on the outputs after edge N+1, if no stall.
  - After redirect edge R: first fetch at edge R+1, first issue after edge R+2.
- Ordering: strict program order. No duplication or loss across stall, and no slot-2 entry issued ahead of slot 1.

Test Plan:
- Reset release; mem[i]=16'h1000+i:
  - After 1st edge: valid=0, q_count=2.
  - After 2nd edge: instr 1000/1001, PCs 0000/0001, valid 1/1.
  - After 3rd edge: 1002/1003.
- Stall held 3 cycles in steady state:
  - Outputs hold 1002/1003; q_count rises to 4 and stays there; fetch_pc stops.
  - On release: 1004/1005, then 1006/1007, with no gaps or repeats.
- redirect_valid=1, redirect_pc=0040 together with stall=1:
  - Next edge: valid 0/0, q_count=0.
  - Two edges later: 1040/1041, PCs 0040/0041.
- Redirect to 0041 (odd):
  - First fetch pushes only 1041.
  - Outputs: instr_1=1041 valid_1=1, valid_2=0, instr_2=0000, pc_out_2=0042.
  - Next: 1042/1043.
- Redirect to FFFE: PCs FFFE/FFFF issued, then 0000/0001; imem_addr wraps to 0000.
- rst asserted between edges during stall with q_count=4: outputs go to 0/NOP and valid 0, q_count=0, imem_addr=0000 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/if_stage_dual.sv
// Dual-wide instruction fetch stage with a small circular fetch queue.
// Fetches aligned two-word blocks and issues up to two in-order instructions.
module if_stage_dual #(
  parameter int          QDEPTH   = 4,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP      = 16'h0000
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic [15:0]                 imem_addr,
  input  logic [15:0]                 imem_rdata_1,
  input  logic [15:0]                 imem_rdata_2,
  input  logic                        stall,
  input  logic                        redirect_valid,
  input  logic [15:0]                 redirect_pc,
  output logic [15:0]                 instr_1,
  output logic [15:0]                 instr_2,
  output logic [15:0]                 pc_out_1,
  output logic [15:0]                 pc_out_2,
  output logic                        valid_1,
  output logic                        valid_2,
  output logic [$clog2(QDEPTH):0]     q_count
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] P_ONE = PW'(1);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [CW-1:0] C_TWO = CW'(2);
  localparam logic [CW-1:0] FETCH_MAX = CW'(QDEPTH - 2);

  logic [15:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   ent_instr_q [QDEPTH];
  logic [15:0]   ent_instr_d [QDEPTH];
  logic [15:0]   ent_pc_q [QDEPTH];
  logic [15:0]   ent_pc_d [QDEPTH];
  logic [15:0]   instr_1_q, instr_1_d;
  logic [15:0]   instr_2_q, instr_2_d;
  logic [15:0]   pc_out_1_q, pc_out_1_d;
  logic [15:0]   pc_out_2_q, pc_out_2_d;
  logic          valid_1_q, valid_1_d;
  logic          valid_2_q, valid_2_d;

  logic          fetch_en;
  logic [CW-1:0] push_n;
  logic [CW-1:0] pop_n;
  logic [PW-1:0] head_nx;
  logic [PW-1:0] tail_nx;

  assign imem_addr = {fetch_pc_q[15:1], 1'b0};
  assign instr_1   = instr_1_q;
  assign instr_2   = instr_2_q;
  assign pc_out_1  = pc_out_1_q;
  assign pc_out_2  = pc_out_2_q;
  assign valid_1   = valid_1_q;
  assign valid_2   = valid_2_q;
  assign q_count   = count_q;

  assign head_nx = head_q + P_ONE;
  assign tail_nx = tail_q + P_ONE;

  // Next-state: redirect flush, else pop to output slots and push fetched words.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    ent_instr_d = ent_instr_q;
    ent_pc_d    = ent_pc_q;
    instr_1_d   = instr_1_q;
    instr_2_d   = instr_2_q;
    pc_out_1_d  = pc_out_1_q;
    pc_out_2_d  = pc_out_2_q;
    valid_1_d   = valid_1_q;
    valid_2_d   = valid_2_q;
    push_n      = '0;
    pop_n       = '0;
    fetch_en    = !redirect_valid && (count_q <= FETCH_MAX);

    if (redirect_valid) begin
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      fetch_pc_d = redirect_pc;
      instr_1_d  = NOP;
      instr_2_d  = NOP;
      valid_1_d  = 1'b0;
      valid_2_d  = 1'b0;
      pc_out_1_d = redirect_pc;
      pc_out_2_d = redirect_pc + 16'd1;
    end else begin
      if (!stall) begin
        if (count_q >= C_TWO) begin
          instr_1_d  = ent_instr_q[head_q];
          pc_out_1_d = ent_pc_q[head_q];
          instr_2_d  = ent_instr_q[head_nx];
          pc_out_2_d = ent_pc_q[head_nx];
          valid_1_d  = 1'b1;
          valid_2_d  = 1'b1;
          head_d     = head_q + PW'(2);
          pop_n      = C_TWO;
        end else if (count_q == C_ONE) begin
          instr_1_d  = ent_instr_q[head_q];
          pc_out_1_d = ent_pc_q[head_q];
          instr_2_d  = NOP;
          pc_out_2_d = ent_pc_q[head_q] + 16'd1;
          valid_1_d  = 1'b1;
          valid_2_d  = 1'b0;
          head_d     = head_nx;
          pop_n      = C_ONE;
        end else begin
          instr_1_d  = NOP;
          instr_2_d  = NOP;
          valid_1_d  = 1'b0;
          valid_2_d  = 1'b0;
        end
      end
      if (fetch_en) begin
        if (!fetch_pc_q[0]) begin
          ent_instr_d[tail_q]  = imem_rdata_1;
          ent_pc_d[tail_q]     = fetch_pc_q;
          ent_instr_d[tail_nx] = imem_rdata_2;
          ent_pc_d[tail_nx]    = fetch_pc_q + 16'd1;
          tail_d               = tail_q + PW'(2);
          fetch_pc_d           = fetch_pc_q + 16'd2;
          push_n               = C_TWO;
        end else begin
          ent_instr_d[tail_q] = imem_rdata_2;
          ent_pc_d[tail_q]    = fetch_pc_q;
          tail_d              = tail_nx;
          fetch_pc_d          = fetch_pc_q + 16'd1;
          push_n              = C_ONE;
        end
      end
      count_d = count_q + push_n - pop_n;
    end
  end

  // State registers; reset discards queued and issued state immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        ent_instr_q[i] <= NOP;
        ent_pc_q[i]    <= '0;
      end
      instr_1_q  <= NOP;
      instr_2_q  <= NOP;
      pc_out_1_q <= RESET_PC;
      pc_out_2_q <= RESET_PC + 16'd1;
      valid_1_q  <= 1'b0;
      valid_2_q  <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      ent_instr_q <= ent_instr_d;
      ent_pc_q    <= ent_pc_d;
      instr_1_q   <= instr_1_d;
      instr_2_q   <= instr_2_d;
      pc_out_1_q  <= pc_out_1_d;
      pc_out_2_q  <= pc_out_2_d;
      valid_1_q   <= valid_1_d;
      valid_2_q   <= valid_2_d;
    end
  end

endmodule
